// File: rtl/mips_pipeline_mem_access_pkg.sv
// Shared types for the MEM stage of the MIPS pipeline.
//   mem_size_e : access width encoding carried in the EX/MEM bundle
//   state_e    : MEM stage sequencer states
//   exmem_t    : EX/MEM pipeline register contents
//   memwb_t    : MEM/WB pipeline register contents, built with pack_memwb()
package mips_pipeline_mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic        mem_read;
        logic        mem_write;
        mem_size_e   mem_size;
        logic        mem_signed;
        logic        reg_write;
        logic [4:0]  reg_dest;
    } exmem_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  reg_dest;
        logic        addr_error;
    } memwb_t;

    function automatic memwb_t pack_memwb(
        input logic [31:0] alu_result,
        input logic [31:0] mem_data,
        input logic        mem_to_reg,
        input logic        reg_write,
        input logic [4:0]  reg_dest,
        input logic        addr_error
    );
        memwb_t r;
        r.alu_result = alu_result;
        r.mem_data   = mem_data;
        r.mem_to_reg = mem_to_reg;
        r.reg_write  = reg_write;
        r.reg_dest   = reg_dest;
        r.addr_error = addr_error;
        return r;
    endfunction

endpackage

// File: rtl/mips_pipeline_mem_access_align.sv
// Combinational byte-lane steering for data-memory accesses.
// Lane order is big-endian: address offset 0 maps to bits [31:24].
// Ports:
//   addr_lo    : address bits [1:0] of the access
//   mem_size   : access width
//   mem_signed : sign-extend loads when set, zero-extend otherwise
//   store_data : register value to store (low byte/half used for narrow stores)
//   rdata      : full word returned by memory
//   load_data  : extracted and extended load result
//   wdata      : store data replicated across all lanes
//   byte_en    : lanes written by the store
module mips_pipeline_mem_access_align
    import mips_pipeline_mem_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   mem_size,
    input  logic        mem_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo)
            2'd0:    rd_byte = rdata[31:24];
            2'd1:    rd_byte = rdata[23:16];
            2'd2:    rd_byte = rdata[15:8];
            default: rd_byte = rdata[7:0];
        endcase
        // Only addr bit 1 selects a halfword; bit 0 is ignored (forced alignment).
        rd_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        load_data = rdata;
        wdata     = store_data;
        byte_en   = 4'b1111;
        case (mem_size)
            MEM_BYTE: begin
                load_data = {{24{mem_signed & rd_byte[7]}}, rd_byte};
                wdata     = {4{store_data[7:0]}};
                byte_en   = 4'b1000 >> addr_lo;
            end
            MEM_HALF: begin
                load_data = {{16{mem_signed & rd_half[15]}}, rd_half};
                wdata     = {2{store_data[15:0]}};
                byte_en   = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                load_data = rdata;
                wdata     = store_data;
                byte_en   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mips_pipeline_mem_access.sv
// MEM stage of the MIPS pipeline: takes one EX/MEM bundle at a time, performs
// the optional data-memory access and presents the MEM/WB bundle downstream.
// Optional feature macro: MIPS_MEM_ALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses skip memory and retire with addrError=1, regWrite=0.
// When undefined, low address bits are ignored and addrError is tied to 0.
// Ports:
//   clock, reset                 : rising-edge clock, async active-low reset
//   pipeIn/Valid/Ready           : upstream EX/MEM handshake
//   pipeOut/Valid/Ready          : downstream MEM/WB handshake
//   flush                        : drop the instruction held by this stage
//   memReq, memWe, memAddr,
//   memWData, memByteEn          : data-memory request (stable until memAck)
//   memAck, memRData             : completion strobe and read data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | empty, accepting a new bundle
// ST_ACCESS | memory request outstanding, waiting for memAck
// ST_DONE   | result presented downstream, waiting for pipeOutReady
module mips_pipeline_mem_access
    import mips_pipeline_mem_access_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  exmem_t      pipeIn,
    input  logic        pipeInValid,
    output logic        pipeInReady,
    output memwb_t      pipeOut,
    output logic        pipeOutValid,
    input  logic        pipeOutReady,
    input  logic        flush,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memByteEn,
    input  logic        memAck,
    input  logic [31:0] memRData
);

    state_e      state_q, state_d;
    exmem_t      held_q, held_d;
    logic [31:0] rdata_q, rdata_d;
    logic        drop_q, drop_d;
    logic        addr_error;

    logic [31:0] load_data;
    logic [31:0] st_wdata;
    logic [3:0]  st_byte_en;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    logic addr_err_q, addr_err_d;

    function automatic logic misaligned(input exmem_t op);
        logic narrow_bad;
        narrow_bad = (op.mem_size == MEM_HALF) ? op.alu_result[0]
                   : (op.mem_size == MEM_BYTE) ? 1'b0
                   : (op.alu_result[1:0] != 2'b00);
        return (op.mem_read | op.mem_write) & narrow_bad;
    endfunction

    assign addr_error = addr_err_q;
`else
    assign addr_error = 1'b0;
`endif

    mips_pipeline_mem_access_align u_align (
        .addr_lo    (held_q.alu_result[1:0]),
        .mem_size   (held_q.mem_size),
        .mem_signed (held_q.mem_signed),
        .store_data (held_q.store_data),
        .rdata      (rdata_q),
        .load_data  (load_data),
        .wdata      (st_wdata),
        .byte_en    (st_byte_en)
    );

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        rdata_d      = rdata_q;
        drop_d       = drop_q;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        addr_err_d   = addr_err_q;
`endif
        pipeInReady  = 1'b0;
        pipeOutValid = 1'b0;
        memReq       = 1'b0;
        memWe        = 1'b0;
        memAddr      = 32'h0;
        memWData     = 32'h0;
        memByteEn    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                pipeInReady = 1'b1;
                // A flush also kills whatever upstream offers this cycle.
                if (pipeInValid && !flush) begin
                    held_d  = pipeIn;
                    rdata_d = 32'h0;
                    drop_d  = 1'b0;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
                    addr_err_d = misaligned(pipeIn);
                    if (misaligned(pipeIn))
                        state_d = ST_DONE;
                    else
`endif
                    if (pipeIn.mem_read || pipeIn.mem_write)
                        state_d = ST_ACCESS;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_ACCESS: begin
                // The request cannot be retracted, so a flush only marks the
                // result to be dropped once memory acknowledges.
                memReq    = 1'b1;
                memWe     = held_q.mem_write;
                memAddr   = {held_q.alu_result[31:2], 2'b00};
                memWData  = st_wdata;
                memByteEn = held_q.mem_write ? st_byte_en : 4'h0;
                if (memAck) begin
                    if (drop_q || flush) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        rdata_d = memRData;
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_DONE: begin
                pipeOutValid = !flush;
                if (flush || pipeOutReady)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pipeOut = pack_memwb(held_q.alu_result,
                                load_data,
                                held_q.mem_read,
                                held_q.reg_write & ~addr_error,
                                held_q.reg_dest,
                                addr_error);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            rdata_q <= 32'h0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            addr_err_q <= 1'b0;
        else
            addr_err_q <= addr_err_d;
    end
`endif

endmodule
